// File: rtl/tproc_pkg.sv
// ---------------------------------------------------------------------------
// tproc_pkg : shared encodings and field positions for the Tproc fetch block
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tproc_pkg;
  localparam int DATA_W_DEF     = 128;
  localparam int EXT_ADDR_W_DEF = 16;
  localparam int BUF_DEPTH_DEF  = 32;
  localparam int BUF_AW_DEF     = 5;
  localparam int INSTR_W_DEF    = 64;

  localparam int INSTR_BASE_LSB = 0;
  localparam int INSTR_CNT_LSB  = 16;
  localparam int INSTR_FIELD_W  = 16;

  localparam int STAT_WCNT_LSB  = 0;
  localparam int STAT_CNT_LSB   = 16;
  localparam int STAT_FIELD_W   = 16;
  localparam int STAT_BUSY_BIT  = 32;
  localparam int STAT_DONE_BIT  = 33;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
endpackage

`default_nettype wire

// File: rtl/tproc_feature_buf.sv
// ---------------------------------------------------------------------------
// tproc_feature_buf : 1W/1R feature buffer, registered read, read-before-write
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tproc_feature_buf
  import tproc_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = BUF_DEPTH_DEF,
  parameter int AW     = BUF_AW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en_i,
  input  logic [AW-1:0]     wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;
endmodule

`default_nettype wire

// File: rtl/tproc_top.sv
// ---------------------------------------------------------------------------
// tproc_top : feature-fetch controller; external RAM -> buffer, host readback
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tproc_top
  import tproc_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int EXT_ADDR_W = EXT_ADDR_W_DEF,
  parameter int BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter int BUF_AW     = BUF_AW_DEF,
  parameter int INSTR_W    = INSTR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  acc_enable,
  input  logic [INSTR_W-1:0]    instr_port,
  input  logic [DATA_W-1:0]     i_data_bus_port,
  output logic [EXT_ADDR_W-1:0] i_feature_addr,
  output logic                  i_feature_rd_en,
  input  logic                  arm_read_feature_enable,
  input  logic [BUF_AW-1:0]     arm_read_feature_addr,
  input  logic                  arm_read_feature_select,
  output logic [DATA_W-1:0]     arm_read_feature_data,
  output logic                  clp_state
);
  localparam int CNT_W = BUF_AW + 1;

  state_e                  state_q;
  logic [EXT_ADDR_W-1:0]   base_q, addr_q;
  logic [CNT_W-1:0]        cnt_q, k_q, wcnt_q;
  logic [BUF_AW-1:0]       iss_idx_q, wr_idx_q;
  logic                    rd_en_q, wr_en_q, done_q, busy_q;
  logic                    sel_q;
  logic [DATA_W-1:0]       status_q, status_d, buf_rd;
  logic [INSTR_FIELD_W-1:0] req_cnt, req_base;
  logic [CNT_W-1:0]        clamp_cnt;
  logic                    unused_instr;

  assign req_base     = instr_port[INSTR_BASE_LSB +: INSTR_FIELD_W];
  assign req_cnt      = instr_port[INSTR_CNT_LSB +: INSTR_FIELD_W];
  assign clamp_cnt    = (req_cnt > INSTR_FIELD_W'(BUF_DEPTH)) ? CNT_W'(BUF_DEPTH)
                                                             : req_cnt[CNT_W-1:0];
  assign unused_instr = ^instr_port[INSTR_W-1:INSTR_CNT_LSB+INSTR_FIELD_W];

  // The first read is issued on the IDLE->FETCH edge; k_q is the next index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      base_q    <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      k_q       <= '0;
      wcnt_q    <= '0;
      iss_idx_q <= '0;
      wr_idx_q  <= '0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      wr_en_q  <= rd_en_q;
      wr_idx_q <= iss_idx_q;
      if (wr_en_q) wcnt_q <= wcnt_q + 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (acc_enable) begin
            base_q <= req_base;
            cnt_q  <= clamp_cnt;
            wcnt_q <= '0;
            if (clamp_cnt == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q   <= ST_FETCH;
              busy_q    <= 1'b1;
              done_q    <= 1'b0;
              rd_en_q   <= 1'b1;
              addr_q    <= req_base;
              iss_idx_q <= '0;
              k_q       <= CNT_W'(1);
            end
          end
        end
        ST_FETCH: begin
          if (k_q == cnt_q) begin
            rd_en_q <= 1'b0;
            state_q <= ST_DRAIN;
          end else begin
            addr_q    <= base_q + EXT_ADDR_W'(k_q);
            iss_idx_q <= k_q[BUF_AW-1:0];
            k_q       <= k_q + 1'b1;
          end
        end
        ST_DRAIN: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        ST_DONE: begin
          if (!acc_enable) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    status_d = '0;
    status_d[STAT_WCNT_LSB +: STAT_FIELD_W] = STAT_FIELD_W'(wcnt_q);
    status_d[STAT_CNT_LSB +: STAT_FIELD_W]  = STAT_FIELD_W'(cnt_q);
    status_d[STAT_BUSY_BIT]                 = busy_q;
    status_d[STAT_DONE_BIT]                 = done_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_q    <= 1'b0;
      status_q <= '0;
    end else if (arm_read_feature_enable) begin
      sel_q <= arm_read_feature_select;
      if (arm_read_feature_select) status_q <= status_d;
    end
  end

  tproc_feature_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH),
    .AW     (BUF_AW)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en_i   (wr_en_q),
    .wr_addr_i (wr_idx_q),
    .wr_data_i (i_data_bus_port),
    .rd_en_i   (arm_read_feature_enable & ~arm_read_feature_select),
    .rd_addr_i (arm_read_feature_addr),
    .rd_data_o (buf_rd)
  );

  assign arm_read_feature_data = sel_q ? status_q : buf_rd;
  assign i_feature_addr        = addr_q;
  assign i_feature_rd_en       = rd_en_q;
  assign clp_state             = busy_q;
endmodule

`default_nettype wire

// File: tb/tb_tproc_top.sv
// ---------------------------------------------------------------------------
// tb_tproc_top : directed self-checking bench for tproc_top
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tproc_top;
  logic         clk;
  logic         rst;
  logic         acc_enable;
  logic [63:0]  instr_port;
  logic [127:0] i_data_bus_port;
  logic [15:0]  i_feature_addr;
  logic         i_feature_rd_en;
  logic         arm_en;
  logic [4:0]   arm_addr;
  logic         arm_sel;
  logic [127:0] arm_data;
  logic         clp_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] ram [64];
  logic [127:0] ram_q;

  tproc_top dut (
    .clk                     (clk),
    .rst                     (rst),
    .acc_enable              (acc_enable),
    .instr_port              (instr_port),
    .i_data_bus_port         (i_data_bus_port),
    .i_feature_addr          (i_feature_addr),
    .i_feature_rd_en         (i_feature_rd_en),
    .arm_read_feature_enable (arm_en),
    .arm_read_feature_addr   (arm_addr),
    .arm_read_feature_select (arm_sel),
    .arm_read_feature_data   (arm_data),
    .clp_state               (clp_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (i_feature_rd_en) ram_q <= ram[i_feature_addr[5:0]];
  end
  assign i_data_bus_port = ram_q;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [127:0] mk_status(input logic d, input logic b,
                                             input logic [15:0] c, input logic [15:0] w);
    logic [127:0] s;
    s        = '0;
    s[33]    = d;
    s[32]    = b;
    s[31:16] = c;
    s[15:0]  = w;
    return s;
  endfunction

  task automatic arm_read(input logic sel, input logic [4:0] a, output logic [127:0] d);
    arm_en   = 1'b1;
    arm_sel  = sel;
    arm_addr = a;
    @(negedge clk);
    arm_en = 1'b0;
    d      = arm_data;
  endtask

  // One start/fetch/drain sequence, watched cycle by cycle from the negedge.
  task automatic run_fetch(input logic [15:0] base, input logic [15:0] cnt, input int exp_n,
                           input int hold, input bit stat, input int coll_k,
                           input logic [127:0] coll_old, input logic [127:0] coll_new);
    int rd_n, busy_n, cyc;
    bit fin;
    rd_n = 0; busy_n = 0; cyc = 0; fin = 0;
    instr_port = {32'h0, cnt, base};
    acc_enable = 1'b1;
    while (!fin && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == hold) acc_enable = 1'b0;
      if (cyc == 1) check("busy_after_start", clp_state, 1'b1);
      if (i_feature_rd_en) begin
        check("rd_addr", i_feature_addr, base + 16'(rd_n));
        rd_n++;
      end
      if (clp_state) busy_n++;
      else fin = 1;
      if (stat && cyc == 1) begin arm_en = 1'b1; arm_sel = 1'b1; end
      if (stat && cyc == 2) begin
        arm_en = 1'b0;
        check("status_fetch_entry", arm_data, mk_status(1'b0, 1'b1, 16'(exp_n), 16'd0));
      end
      if (coll_k >= 0 && cyc == coll_k + 2) begin
        arm_en = 1'b1; arm_sel = 1'b0; arm_addr = 5'(coll_k);
      end
      if (coll_k >= 0 && cyc == coll_k + 3) check("coll_old", arm_data, coll_old);
      if (coll_k >= 0 && cyc == coll_k + 4) begin
        check("coll_new", arm_data, coll_new);
        arm_en = 1'b0;
      end
    end
    check("fetch_done", fin, 1'b1);
    check("rd_count", rd_n, exp_n);
    check("busy_cycles", busy_n, exp_n + 1);
    acc_enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] d;
    for (int i = 0; i < 64; i++) ram[i] = 128'(i + 1);
    rst = 1'b1; acc_enable = 1'b0; instr_port = '0;
    arm_en = 1'b0; arm_addr = '0; arm_sel = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_rd_en", i_feature_rd_en, 1'b0);
    check("rst_addr", i_feature_addr, 16'd0);
    check("rst_arm_data", arm_data, 128'd0);
    check("rst_clp", clp_state, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    arm_read(1'b1, 5'd0, d);
    check("status_after_reset", d, 128'd0);

    // basic fetch of 16 words from address 0
    run_fetch(16'd0, 16'd16, 16, 10, 1'b0, -1, '0, '0);
    for (int i = 0; i < 16; i++) begin
      arm_read(1'b0, 5'(i), d);
      check("basic_buf", d, 128'(i + 1));
    end
    arm_read(1'b1, 5'd0, d);
    check("status_done", d, mk_status(1'b1, 1'b0, 16'd16, 16'd16));
    @(negedge clk);
    check("arm_hold", arm_data, mk_status(1'b1, 1'b0, 16'd16, 16'd16));

    // clamp to depth with offset; done must clear on FETCH entry
    run_fetch(16'd4, 16'd40, 32, 3, 1'b1, -1, '0, '0);
    arm_read(1'b0, 5'd0, d);
    check("clamp_buf0", d, 128'd5);
    arm_read(1'b0, 5'd31, d);
    check("clamp_buf31", d, 128'd36);
    arm_read(1'b1, 5'd0, d);
    check("clamp_status", d, mk_status(1'b1, 1'b0, 16'd32, 16'd32));

    // zero count goes straight to DONE
    instr_port = {32'h0, 16'd0, 16'd7};
    acc_enable = 1'b1;
    @(negedge clk);
    check("zero_rd_en_c1", i_feature_rd_en, 1'b0);
    check("zero_busy_c1", clp_state, 1'b0);
    arm_en = 1'b1; arm_sel = 1'b1;
    @(negedge clk);
    arm_en = 1'b0;
    check("zero_rd_en_c2", i_feature_rd_en, 1'b0);
    check("zero_status", arm_data, mk_status(1'b1, 1'b0, 16'd0, 16'd0));
    acc_enable = 1'b0;
    repeat (2) @(negedge clk);

    // asynchronous reset on the 5th FETCH cycle
    instr_port = {32'h0, 16'd16, 16'd0};
    acc_enable = 1'b1;
    repeat (5) @(negedge clk);
    check("pre_reset_rd_en", i_feature_rd_en, 1'b1);
    check("pre_reset_addr", i_feature_addr, 16'd4);
    rst = 1'b0;
    acc_enable = 1'b0;
    #1;
    check("mid_reset_rd_en", i_feature_rd_en, 1'b0);
    check("mid_reset_clp", clp_state, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    arm_read(1'b1, 5'd0, d);
    check("status_after_mid_reset", d, 128'd0);
    arm_read(1'b0, 5'd2, d);
    check("partial_buf2", d, 128'd3);

    // restart; collide ARM read with the write of buffer[5]
    run_fetch(16'd8, 16'd8, 8, 4, 1'b0, 5, 128'd10, 128'd14);
    for (int i = 0; i < 8; i++) begin
      arm_read(1'b0, 5'(i), d);
      check("restart_buf", d, 128'(i + 9));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
